// File: rtl/baud_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_rate_gen
// Brief    : Fractional baud-rate generator. Emits an oversample tick at an
//            average period of div_int + div_frac/2^FRAC_W clocks, a bit tick
//            every OVS oversample ticks, and the current oversample phase.
//            Divisor reloads only take effect on a period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module baud_rate_gen #(
  parameter int CNT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 81,
  parameter int DEF_FRAC = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [CNT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  input  logic                    sync_clr,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  os_phase,
  output logic                    pend
);

  localparam int                      c_ph_w     = $clog2(OVS);
  localparam logic [CNT_W-1:0]        c_def_int  = CNT_W'(DEF_INT);
  localparam logic [FRAC_W-1:0]       c_def_frac = FRAC_W'(DEF_FRAC);
  localparam logic [CNT_W-1:0]        c_min_int  = CNT_W'(2);
  localparam logic [c_ph_w-1:0]       c_last_ph  = c_ph_w'(OVS - 1);

  // Active divisor (drives the counter) and shadow divisor (written by div_load)
  logic [CNT_W-1:0]   r_act_int;
  logic [FRAC_W-1:0]  r_act_frac;
  logic [CNT_W-1:0]   r_sh_int;
  logic [FRAC_W-1:0]  r_sh_frac;
  logic               r_pend;

  // Period counter, phase accumulator and run flag (low = idle, next edge starts)
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAC_W-1:0]  r_acc;
  logic               r_run;
  logic [c_ph_w-1:0]  r_phase;
  logic               r_os_tick;
  logic               r_bit_tick;

  logic [CNT_W-1:0]   w_cap_int;
  logic               w_tick;
  logic               w_restart;
  logic               w_use_sh;
  logic [CNT_W-1:0]   w_sel_int;
  logic [FRAC_W-1:0]  w_sel_frac;
  logic [FRAC_W:0]    w_sum;
  logic [CNT_W-1:0]   w_reload;

  // Divisors below 2 cannot produce a one-cycle tick followed by a gap
  assign w_cap_int = (div_int < c_min_int) ? c_min_int : div_int;

  // Counter expired on this edge: the registered tick rises after it
  assign w_tick    = r_run && (r_cnt == '0);
  assign w_restart = en && sync_clr;

  // Shadow is promoted at a period boundary, at start-up, or whenever idle
  assign w_use_sh  = r_pend && (!en || !r_run || w_tick);

  // Divisor that governs the period starting at this edge
  always_comb begin
    w_sel_int  = r_act_int;
    w_sel_frac = r_act_frac;
    if (w_restart) begin
      if (div_load) begin
        w_sel_int  = w_cap_int;
        w_sel_frac = div_frac;
      end else if (r_pend) begin
        w_sel_int  = r_sh_int;
        w_sel_frac = r_sh_frac;
      end
    end else if (w_use_sh) begin
      w_sel_int  = r_sh_int;
      w_sel_frac = r_sh_frac;
    end
  end

  // A carry out of the accumulator stretches the next period by one clock.
  // The counter reloads with (period - 1), so N+1 still fits in CNT_W bits.
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_sel_frac};
  assign w_reload = w_sum[FRAC_W] ? w_sel_int : (w_sel_int - CNT_W'(1));

  // Divisor shadow capture, active promotion and pending flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_int  <= c_def_int;
      r_act_frac <= c_def_frac;
      r_sh_int   <= c_def_int;
      r_sh_frac  <= c_def_frac;
      r_pend     <= 1'b0;
    end else begin
      r_act_int  <= w_sel_int;
      r_act_frac <= w_sel_frac;
      if (div_load) begin
        r_sh_int  <= w_cap_int;
        r_sh_frac <= div_frac;
      end
      if (w_restart) begin
        r_pend <= 1'b0;
      end else if (div_load) begin
        r_pend <= 1'b1;
      end else if (w_use_sh) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Period counter, fractional accumulator, phase and registered ticks.
  // A restart (en rising or sync_clr) loads N-1 so the first tick lands N
  // clocks after the restart edge; the accumulator always restarts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run      <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_phase    <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (!en) begin
      r_run      <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_phase    <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (sync_clr || !r_run) begin
      r_run      <= 1'b1;
      r_cnt      <= w_sel_int - CNT_W'(1);
      r_acc      <= '0;
      r_phase    <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (w_tick) begin
      r_cnt      <= w_reload;
      r_acc      <= w_sum[FRAC_W-1:0];
      r_phase    <= r_phase + c_ph_w'(1);
      r_os_tick  <= 1'b1;
      r_bit_tick <= (r_phase == c_last_ph);
    end else begin
      r_cnt      <= r_cnt - CNT_W'(1);
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end
  end

  assign os_tick  = r_os_tick;
  assign bit_tick = r_bit_tick;
  assign os_phase = r_phase;
  assign pend     = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_baud_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_rate_gen
// Brief    : Directed + randomized bench for baud_rate_gen. Expected tick
//            times come from an arithmetic period model (N plus accumulator
//            carry), independent of the counter implementation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_rate_gen;

  localparam int CW  = 10;
  localparam int FW  = 4;
  localparam int OVS = 16;

  logic          clk;
  logic          reset    = 1'b1;
  logic          en       = 1'b0;
  logic          div_load = 1'b0;
  logic          sync_clr = 1'b0;
  logic [CW-1:0] div_int  = '0;
  logic [FW-1:0] div_frac = '0;
  logic          os_tick;
  logic          bit_tick;
  logic [3:0]    os_phase;
  logic          pend;

  baud_rate_gen #(
    .CNT_W(CW), .FRAC_W(FW), .OVS(OVS), .DEF_INT(81), .DEF_FRAC(6)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .sync_clr(sync_clr), .os_tick(os_tick),
    .bit_tick(bit_tick), .os_phase(os_phase), .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  // Reference model: active/shadow divisor, accumulator, phase, next tick time
  int m_n, m_f, m_sn, m_sf, m_acc, m_phase, t_exp;
  bit m_pend;
  int bt_q[$];

  function automatic int clamp2(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_pend();
    if (m_pend) begin
      m_n    = m_sn;
      m_f    = m_sf;
      m_pend = 1'b0;
    end
  endtask

  // Wait (bounded) for the next os_tick and check it against the model
  task automatic take_tick(input string tag);
    int lim;
    int carry;
    bit exp_bit;
    lim = t_exp + 3;
    do begin
      step();
      if (bit_tick === 1'b1 && os_tick !== 1'b1) chk({tag, "_bit_alone"}, 1, 0);
    end while (os_tick !== 1'b1 && cyc < lim);
    chk({tag, "_time"}, cyc, t_exp);
    apply_pend();
    exp_bit = (m_phase == OVS - 1);
    m_phase = (m_phase + 1) % OVS;
    m_acc   = m_acc + m_f;
    carry   = (m_acc >= (1 << FW)) ? 1 : 0;
    m_acc   = m_acc % (1 << FW);
    t_exp   = cyc + m_n + carry;
    chk({tag, "_bit"}, bit_tick, exp_bit);
    chk({tag, "_phase"}, os_phase, m_phase);
    chk({tag, "_pend"}, pend, m_pend);
    if (bit_tick === 1'b1) bt_q.push_back(cyc);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) take_tick(tag);
  endtask

  task automatic start_en();
    en = 1'b1;
    step();
    apply_pend();
    m_acc   = 0;
    m_phase = 0;
    t_exp   = cyc + m_n;
  endtask

  task automatic load(input int ni, input int nf);
    div_int  = CW'(ni);
    div_frac = FW'(nf);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    m_sn   = clamp2(ni);
    m_sf   = nf;
    m_pend = 1'b1;
  endtask

  task automatic do_sync(input bit with_load, input int ni, input int nf);
    sync_clr = 1'b1;
    if (with_load) begin
      div_int  = CW'(ni);
      div_frac = FW'(nf);
      div_load = 1'b1;
    end
    step();
    sync_clr = 1'b0;
    div_load = 1'b0;
    if (with_load) begin
      m_n = clamp2(ni); m_f = nf; m_sn = m_n; m_sf = nf; m_pend = 1'b0;
    end else begin
      apply_pend();
    end
    m_acc   = 0;
    m_phase = 0;
    t_exp   = cyc + m_n;
    chk("sync_os", os_tick, 0);
    chk("sync_bit", bit_tick, 0);
    chk("sync_phase", os_phase, 0);
    chk("sync_pend", pend, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, f, guard, cnt;

    // Reset state
    step(); step();
    chk("rst_os", os_tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_phase", os_phase, 0);
    chk("rst_pend", pend, 0);
    reset = 1'b0;
    step();
    m_n = 81; m_f = 6; m_sn = 81; m_sf = 6; m_pend = 1'b0;

    // Defaults 81 + 6/16: bit spacing 16*81 + 6
    start_en();
    run(40, "dflt");
    chk("dflt_nbit", bt_q.size(), 2);
    if (bt_q.size() >= 2) chk("dflt_bitspace", bt_q[1] - bt_q[0], 1302);

    // Integer-only divisor: bit spacing 16*81
    bt_q.delete();
    load(81, 0);
    run(40, "f0");
    chk("f0_nbit", bt_q.size(), 3);
    if (bt_q.size() >= 3) chk("f0_bitspace", bt_q[2] - bt_q[1], 1296);

    // Mid-period load: current period keeps its length, pend until boundary
    k = $urandom_range(0, 60);
    repeat (k) step();
    load(10, 0);
    chk("mid_pend", pend, 1);
    run(20, "mid");

    // Clamp of 0 and 1, then the largest divisor with full fraction
    load(0, 0);  run(5, "clamp0");
    load(1, 0);  run(5, "clamp1");
    load((1 << CW) - 1, 15); run(3, "big");

    // Random divisors
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 40);
      f = $urandom_range(0, 15);
      load(n, f);
      run(20, "rnd");
    end

    // sync_clr at phase 7
    load(20, 5);
    run(2, "pre");
    guard = 0;
    while (m_phase != 7 && guard < 20) begin
      take_tick("to7");
      guard++;
    end
    chk("at_phase7", os_phase, 7);
    k = $urandom_range(0, 17);
    repeat (k) step();
    bt_q.delete();
    do_sync(1'b0, 0, 0);
    run(17, "clr");
    chk("clr_nbit", bt_q.size(), 1);

    // sync_clr exactly on the edge where the counter expires
    while (cyc < t_exp - 1) step();
    do_sync(1'b0, 0, 0);
    run(3, "clr_edge");

    // sync_clr together with div_load: new divisor from the restart
    n = $urandom_range(2, 30);
    f = $urandom_range(0, 15);
    do_sync(1'b1, n, f);
    run(5, "clr_ld");

    // Pending load promoted by sync_clr
    load(25, 2);
    chk("pre_clr_pend", pend, 1);
    do_sync(1'b0, 0, 0);
    run(3, "clr_pend");

    // Drop en mid-period: idle, no ticks, loads still land
    run(1, "pre_dis");
    repeat (5) step();
    en = 1'b0;
    step();
    chk("dis_os", os_tick, 0);
    chk("dis_phase", os_phase, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (os_tick === 1'b1) cnt++;
    end
    chk("dis_noticks", cnt, 0);
    load(12, 3);
    chk("dis_pend_set", pend, 1);
    step();
    chk("dis_pend_clr", pend, 0);
    apply_pend();
    start_en();
    run(5, "reen");

    // Asynchronous reset mid-period with a load pending
    load(30, 9);
    chk("prerst_pend", pend, 1);
    repeat (3) step();
    #3 reset = 1'b1;
    #1;
    chk("arst_os", os_tick, 0);
    chk("arst_bit", bit_tick, 0);
    chk("arst_phase", os_phase, 0);
    chk("arst_pend", pend, 0);
    step(); step();
    reset = 1'b0;
    m_n = 81; m_f = 6; m_sn = 81; m_sf = 6; m_pend = 1'b0;
    start_en();
    run(17, "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_rate_gen.md
Name: baud_rate_gen

Overview:
Runtime-programmable fractional baud-rate generator for the UART TX/RX datapath. Produces an oversample tick (os_tick) at an average period of div_int + div_frac/2^FRAC_W clk cycles. Also produces a bit tick (bit_tick) every OVS oversample ticks, plus the current oversample phase. Supports glitch-free divisor reload, enable gating and a synchronous phase restart, which RX uses to realign on start-bit detect.

Parameters:
CNT_W, 16, width of the integer divisor and down-counter
FRAC_W, 4, width of the fractional divisor and phase accumulator
OVS, 16, oversample ticks per bit (power of two, >= 2)
DEF_INT, 81, integer divisor loaded at reset (50 MHz / (38400*16) = 81.38)
DEF_FRAC, 6, fractional divisor loaded at reset (6/16 = 0.375)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  generator enable; low = counter idle, no ticks
div_int  in  CNT_W  new integer divisor, captured on div_load
div_frac  in  FRAC_W  new fractional divisor, captured on div_load
div_load  in  1  single-cycle strobe to capture div_int/div_frac into shadow regs
sync_clr  in  1  synchronous restart of counter, accumulator and phase
os_tick  out  1  one-cycle oversample tick (registered)
bit_tick  out  1  one-cycle bit tick, coincident with the os_tick that ends phase OVS-1 (registered)
os_phase  out  clog2(OVS)  oversample index within the current bit
pend  out  1  high while a loaded divisor is waiting to take effect

Behaviour:
- Reset (async, any time):
  - active and shadow divisors = DEF_INT/DEF_FRAC.
  - counter, accumulator, os_phase = 0.
  - os_tick = bit_tick = pend = 0.
- Effective integer divisor N = max(div_int, 2). Values 0 and 1 clamp to 2. The clamp is applied at capture.
- Period rule, with en=1:
  - The counter runs down from its reload value. When it reaches 0, os_tick is asserted for exactly one cycle.
  - On that same cycle, acc_next = acc + frac (FRAC_W bits, wraps).
  - If the add carries, the next period is N+1 cycles; otherwise it is N cycles.
  - Over 2^FRAC_W ticks, exactly frac periods are N+1 long.
- First tick: en sampled high at edge 0 (counter idle) → os_tick high in the cycle following edge N. The first period always uses acc=0.
- os_phase:
  - Increments modulo OVS on each os_tick.
  - bit_tick = os_tick AND (os_phase == OVS-1) before the increment.
  - bit_tick therefore never asserts without os_tick.
- Divisor load:
  - div_load captures the inputs into the shadow regs and sets pend.
  - With en=1, the shadow copies to active on the os_tick cycle, so the following period uses the new value. The current period is never shortened or stretched. pend clears on that same cycle.
  - With en=0, the copy happens on the next edge and pend clears then.
  - A second div_load while pend=1 overwrites the shadow (last write wins).
- en low:
  - Counter, accumulator and os_phase are held at 0.
  - No ticks are produced. Shadow loads still apply.
  - Dropping en mid-period discards that period; no partial tick is emitted.
- sync_clr (with en=1):
  - Counter, accumulator and os_phase go to 0 on the next edge. The next os_tick follows N cycles later (same as first-tick rule).
  - No os_tick or bit_tick is asserted in the cycle following sync_clr, even if the counter was at 0.
  - sync_clr + div_load in the same cycle: the load is captured and applied immediately, so the restarted period uses the new divisor and pend stays 0.
  - sync_clr has priority over a pending os_tick-boundary copy. The pending copy is applied at the restart instead.
- Arithmetic: counter is CNT_W bits, unsigned, no overflow possible since reload ≤ 2^CNT_W-1. The N+1 reload uses a CNT_W+1-bit compare path or saturates at 2^CNT_W-1.

Test Plan:
1. Reset, en=1, defaults, then load frac=0 → os_tick every 81 cycles exactly. bit_tick every 1296 cycles. os_phase steps 0..15.
2. Defaults (81, frac 6), run 64 os_ticks → each window of 16 ticks has 6 periods of 82 and 10 of 81. bit_tick spacing = 1302 cycles.
3. Mid-period div_load div_int=10 frac=0 → current period finishes at old length, pend high until that os_tick, all subsequent periods 10.
4. Load div_int=0, then 1 → os_tick period 2 for each. Load 65535 frac 15 → no counter wrap, periods 65535/65536.
5. sync_clr at os_phase=7 → os_phase=0, no tick next cycle, next os_tick N cycles later, bit_tick after 16 more ticks. Repeat with div_load in the same cycle: new N used immediately, pend=0.
6. Drop en mid-period → no ticks, os_phase=0. Re-enable → first tick after N cycles. Assert reset mid-period → outputs 0 asynchronously, divisor back to 81/6.
